wb_trace_buffer: RTL and testbench
==================================

Name: wb_trace_buffer

Overview:
- Retirement trace capture sitting directly downstream of the pipelined datapath.
- Consumes the datapath's debug outputs:
  - writeback register write: reg_num / reg_data / reg_write_sig
  - data-memory access: wr / reade / addr / wr_data / rd_data
- Packs each event into a record, queues it in a FIFO, and drains it over a valid/ready port to the bench monitor or a UART bridge.
- Gives in-order, cycle-stamped, lossless-unless-full visibility of architectural state changes.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 4.
- DATA_W, 32, data width of register and memory values.
- DM_ADDRESS, 9, data-memory address width.
- TS_W, 16, cycle-stamp width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- trace_en  in  1  when 0, no event is captured; drain continues.
- clr_ovf  in  1  clears overflow and drop_count.
- reg_write_sig  in  1  writeback register write strobe.
- reg_num  in  5  destination register.
- reg_data  in  DATA_W  value written.
- wr  in  1  data-memory write strobe.
- reade  in  1  data-memory read strobe.
- addr  in  DM_ADDRESS  data-memory address.
- wr_data  in  DATA_W  store data.
- rd_data  in  DATA_W  load data, valid in the same cycle as reade.
- trc_valid  out  1  head record available.
- trc_ready  in  1  consumer accepts the head record.
- trc_kind  out  2  record kind: 00 REG, 01 STORE, 10 LOAD.
- trc_index  out  9  register number zero-extended, or memory address.
- trc_data  out  DATA_W  value.
- trc_ts  out  TS_W  cycle stamp.
- fill_count  out  $clog2(DEPTH)+1  occupied entries.
- overflow  out  1  sticky; set when any event is dropped.
- drop_count  out  8  number of dropped events, saturates at 255.

Behaviour:
- Reset value of every output is 0: FIFO empty, trc_valid=0, overflow=0, drop_count=0, cycle counter=0.

Event detection (per cycle, only when trace_en=1):
- REG event: reg_write_sig=1 and reg_num!=0. Writes to x0 are never recorded.
- MEM event: wr=1 gives STORE with data=wr_data. Otherwise reade=1 gives LOAD with data=rd_data.
- wr and reade both high: treated as STORE only.

Ordering:
- At most 2 events per cycle.
- REG is written first, because it belongs to the older instruction; MEM is second.

Push and space rules:
- Free space = DEPTH − fill_count, using the start-of-cycle value. A pop in the same cycle does not create space for that cycle's push.
- Two events, free ≥ 2: both pushed.
- Two events, free = 1: REG pushed, MEM dropped.
- Any event with free = 0: dropped.
- Each dropped event sets overflow and increments drop_count, saturating at 255.

Drain:
- Show-ahead: trc_* reflect the head entry whenever trc_valid=1.
- Pop happens when trc_valid & trc_ready.
- trc_* stay stable while trc_valid=1 and trc_ready=0.
- trc_valid = (fill_count != 0), registered state.
- Latency: an event captured in cycle N is visible at the head in cycle N+1 if the FIFO was empty.

Counts and pointers:
- fill_count updates each cycle: fill_count + pushes − pop.
- Read and write pointers are DEPTH-modulo and wrap naturally.

Cycle counter:
- Free-running TS_W-bit counter, wraps from 2^TS_W−1 to 0.
- Stamp = counter value in the capture cycle; both records of a dual push get the same stamp.

Overflow clear:
- clr_ovf has priority over a same-cycle drop: both fields clear, and that cycle's drop is not counted.

Reset mid-operation:
- FIFO contents are discarded and all outputs return to 0 in the next cycle, regardless of trc_ready.

trace_en:
- Deasserting trace_en does not flush the FIFO.

Optional Feature:
- Macro: TRACE_TIMESTAMP_EN.
- Defined: the cycle counter exists and trc_ts carries the stamp.
- Undefined: no counter, no stamp storage in the FIFO; trc_ts is tied to 0.

Decomposition:
- Package Trace_PKG:
  - trace_kind_e enum: REG=2'b00, STORE=2'b01, LOAD=2'b10.
  - trace_rec_t packed struct: kind, index[8:0], data, ts.
  - constant DROP_SAT=8'd255.
- Sub-module trace_fifo:
  - dual-push (push0/push1, rec0/rec1), single-pop show-ahead FIFO of trace_rec_t.
  - outputs count.
  - the top level does event detection, ordering, space checks and drop accounting.

Test Plan:
- Reset, then reg_write_sig=1, reg_num=5, reg_data=0x0000002A for 1 cycle -> next cycle trc_valid=1, kind=00, index=5, data=0x2A, fill_count=1; pop -> fill_count=0.
- Same cycle: reg write x3=0x11 and wr=1, addr=0x010, wr_data=0xDEADBEEF -> two records in order REG(3,0x11) then STORE(0x010,0xDEADBEEF), equal trc_ts.
- reg_write_sig=1 with reg_num=0 plus reade=1, addr=0x020, rd_data=0x7 -> only LOAD(0x020,0x7) recorded, fill_count=1.
- trc_ready=0, push 16 REG events, then 1 more plus a dual event -> fill_count=16, overflow=1, drop_count=3, head still equals the first record.
- Fill to DEPTH−1 with trc_ready=0, then a dual event -> REG accepted, MEM dropped, fill_count=16, drop_count=1; then clr_ovf=1 together with a further drop -> overflow=0, drop_count=0.
- With TRACE_TIMESTAMP_EN defined: capture 2^16 cycles apart -> stamps equal, confirming wrap. Assert reset while the FIFO holds 5 entries -> next cycle trc_valid=0, fill_count=0.

Source files
------------

// File: rtl/wb_trace_buffer_pkg.sv
// Trace_PKG: record layout, record kinds and drop-counter saturation for wb_trace_buffer.
// Latency: n/a (types and helper function only).
// Backpressure: n/a. When TRACE_TIMESTAMP_EN is defined, each record also carries a cycle stamp.
package Trace_PKG;

    localparam int          REC_DATA_W = 32;
    localparam int          REC_TS_W   = 16;
    localparam logic [7:0]  DROP_SAT   = 8'd255;

    typedef enum logic [1:0] {
        REG   = 2'b00,
        STORE = 2'b01,
        LOAD  = 2'b10
    } trace_kind_e;

    typedef struct packed {
        trace_kind_e             kind;
        logic [8:0]              index;
        logic [REC_DATA_W-1:0]   data;
`ifdef TRACE_TIMESTAMP_EN
        logic [REC_TS_W-1:0]     ts;
`endif
    } trace_rec_t;

    // Adds up to two drops to the counter and clamps the result at DROP_SAT.
    function automatic logic [7:0] drop_add(input logic [7:0] cnt, input logic [1:0] n);
        logic [8:0] sum;
        sum = {1'b0, cnt} + {7'b0, n};
        return sum[8] ? DROP_SAT : sum[7:0];
    endfunction

endpackage

// File: rtl/wb_trace_buffer_fifo.sv
// trace_fifo: dual-push, single-pop show-ahead queue of trace records.
// Latency: a record pushed in cycle N is readable at the head in cycle N+1.
// Backpressure: the head holds while rd_rdy_i=0; the caller pushes only into free space.
module trace_fifo
    import Trace_PKG::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           push0_i,
    input  logic           push1_i,
    input  trace_rec_t     rec0_i,
    input  trace_rec_t     rec1_i,
    output logic           rd_vld_o,
    input  logic           rd_rdy_i,
    output trace_rec_t     head_o,
    output logic [CW-1:0]  count_o
);

    trace_rec_t     mem_q [DEPTH];
    logic [AW-1:0]  wptr_q, wptr_d;
    logic [AW-1:0]  rptr_q, rptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           pop;

    assign rd_vld_o = (count_q != '0);
    assign pop      = rd_vld_o & rd_rdy_i;
    assign head_o   = mem_q[rptr_q];
    assign count_o  = count_q;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wptr_d  = wptr_q + AW'(push0_i) + AW'(push1_i);
        rptr_d  = rptr_q + AW'(pop);
        count_d = count_q + CW'(push0_i) + CW'(push1_i) - CW'(pop);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage; rec1 only ever lands directly behind rec0, so it goes to wptr+1.
    always_ff @(posedge clk) begin
        if (push0_i) mem_q[wptr_q] <= rec0_i;
        if (push1_i) mem_q[wptr_q + AW'(1)] <= rec1_i;
    end

endmodule

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: captures writeback/data-memory events into a FIFO for an external monitor.
// Latency: an event captured in cycle N reaches the head in cycle N+1 when the FIFO is empty.
// Backpressure: trc_* hold while trc_ready=0; events arriving without space are dropped and counted.
// Optional: TRACE_TIMESTAMP_EN adds a free-running cycle stamp to every record.
module wb_trace_buffer
    import Trace_PKG::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9,
    parameter int TS_W       = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     trace_en,
    input  logic                     clr_ovf,
    input  logic                     reg_write_sig,
    input  logic [4:0]               reg_num,
    input  logic [DATA_W-1:0]        reg_data,
    input  logic                     wr,
    input  logic                     reade,
    input  logic [DM_ADDRESS-1:0]    addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W-1:0]        rd_data,
    output logic                     trc_valid,
    input  logic                     trc_ready,
    output logic [1:0]               trc_kind,
    output logic [8:0]               trc_index,
    output logic [DATA_W-1:0]        trc_data,
    output logic [TS_W-1:0]          trc_ts,
    output logic [$clog2(DEPTH):0]   fill_count,
    output logic                     overflow,
    output logic [7:0]               drop_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic           ev_reg;
    logic           ev_mem;
    logic [CW-1:0]  free;
    trace_rec_t     reg_rec;
    trace_rec_t     mem_rec;
    trace_rec_t     rec0;
    trace_rec_t     rec1;
    trace_rec_t     head;
    logic           push0;
    logic           push1;
    logic [1:0]     n_drop;
    logic           overflow_q, overflow_d;
    logic [7:0]     drop_cnt_q, drop_cnt_d;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;

    // Free-running cycle counter; wraps to zero.
    always_comb begin
        ts_d = ts_q + TS_W'(1);
    end

    // Cycle counter register.
    always_ff @(posedge clk) begin
        if (reset) ts_q <= '0;
        else       ts_q <= ts_d;
    end
`endif

    // x0 writes never change architectural state, so they are not traced.
    assign ev_reg = trace_en & reg_write_sig & (reg_num != 5'd0);
    assign ev_mem = trace_en & (wr | reade);

    // Space is judged on the start-of-cycle fill; a same-cycle pop does not help.
    assign free = CW'(DEPTH) - fill_count;

    // Build the candidate records; a store wins over a load when both strobes are high.
    always_comb begin
        reg_rec       = '0;
        reg_rec.kind  = REG;
        reg_rec.index = {4'b0, reg_num};
        reg_rec.data  = reg_data;
        mem_rec       = '0;
        mem_rec.kind  = wr ? STORE : LOAD;
        mem_rec.index = 9'(addr);
        mem_rec.data  = wr ? wr_data : rd_data;
`ifdef TRACE_TIMESTAMP_EN
        reg_rec.ts    = ts_q;
        mem_rec.ts    = ts_q;
`endif
    end

    // Order events (REG belongs to the older instruction) and decide pushes versus drops.
    always_comb begin
        push0  = 1'b0;
        push1  = 1'b0;
        n_drop = 2'd0;
        rec0   = ev_reg ? reg_rec : mem_rec;
        rec1   = mem_rec;
        if (ev_reg && ev_mem) begin
            if (free >= CW'(2)) begin
                push0 = 1'b1;
                push1 = 1'b1;
            end else if (free == CW'(1)) begin
                push0  = 1'b1;
                n_drop = 2'd1;
            end else begin
                n_drop = 2'd2;
            end
        end else if (ev_reg || ev_mem) begin
            if (free != '0) push0  = 1'b1;
            else            n_drop = 2'd1;
        end
    end

    // Drop accounting; a clear in the same cycle as a drop wins and the drop is not counted.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clr_ovf) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end else if (n_drop != 2'd0) begin
            overflow_d = 1'b1;
            drop_cnt_d = drop_add(drop_cnt_q, n_drop);
        end
    end

    // Overflow and drop-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    trace_fifo #(
        .DEPTH    (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push0_i  (push0),
        .push1_i  (push1),
        .rec0_i   (rec0),
        .rec1_i   (rec1),
        .rd_vld_o (trc_valid),
        .rd_rdy_i (trc_ready),
        .head_o   (head),
        .count_o  (fill_count)
    );

    // Head fields are masked when empty so stale storage never shows on the port.
    assign trc_kind   = trc_valid ? 2'(head.kind) : 2'b00;
    assign trc_index  = trc_valid ? head.index    : 9'd0;
    assign trc_data   = trc_valid ? head.data     : '0;
`ifdef TRACE_TIMESTAMP_EN
    assign trc_ts     = trc_valid ? head.ts       : '0;
`else
    assign trc_ts     = '0;
`endif
    assign overflow   = overflow_q;
    assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer: capture, ordering, drop/overflow, drain and reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// With TRACE_TIMESTAMP_EN defined, the counter wrap is also exercised.
module tb_wb_trace_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        trace_en;
    logic        clr_ovf;
    logic        reg_write_sig;
    logic [4:0]  reg_num;
    logic [31:0] reg_data;
    logic        wr;
    logic        reade;
    logic [8:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        trc_valid;
    logic        trc_ready;
    logic [1:0]  trc_kind;
    logic [8:0]  trc_index;
    logic [31:0] trc_data;
    logic [15:0] trc_ts;
    logic [4:0]  fill_count;
    logic        overflow;
    logic [7:0]  drop_count;

    int n_chk  = 0;
    int n_pass = 0;

    logic [15:0] ts_a;

    wb_trace_buffer dut (
        .clk           (clk),
        .reset         (reset),
        .trace_en      (trace_en),
        .clr_ovf       (clr_ovf),
        .reg_write_sig (reg_write_sig),
        .reg_num       (reg_num),
        .reg_data      (reg_data),
        .wr            (wr),
        .reade         (reade),
        .addr          (addr),
        .wr_data       (wr_data),
        .rd_data       (rd_data),
        .trc_valid     (trc_valid),
        .trc_ready     (trc_ready),
        .trc_kind      (trc_kind),
        .trc_index     (trc_index),
        .trc_data      (trc_data),
        .trc_ts        (trc_ts),
        .fill_count    (fill_count),
        .overflow      (overflow),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reg_write_sig = 1'b0;
        reg_num       = 5'd0;
        reg_data      = 32'd0;
        wr            = 1'b0;
        reade         = 1'b0;
        addr          = 9'd0;
        wr_data       = 32'd0;
        rd_data       = 32'd0;
    endtask

    task automatic push_reg(input logic [4:0] n, input logic [31:0] d);
        reg_write_sig = 1'b1;
        reg_num       = n;
        reg_data      = d;
        cyc();
        idle();
    endtask

    task automatic pop1();
        trc_ready = 1'b1;
        cyc();
        trc_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        trace_en  = 1'b1;
        clr_ovf   = 1'b0;
        trc_ready = 1'b0;
        idle();
        cyc();
        cyc();
        chk("rst_valid", 64'(trc_valid), 64'd0);
        chk("rst_fill",  64'(fill_count), 64'd0);
        chk("rst_ovf",   64'(overflow), 64'd0);
        chk("rst_drop",  64'(drop_count), 64'd0);
        chk("rst_data",  64'(trc_data), 64'd0);
        reset = 1'b0;
        cyc();

        // Single REG event, visible next cycle, then popped.
        push_reg(5'd5, 32'h0000_002A);
        chk("t1_valid", 64'(trc_valid), 64'd1);
        chk("t1_kind",  64'(trc_kind), 64'd0);
        chk("t1_index", 64'(trc_index), 64'd5);
        chk("t1_data",  64'(trc_data), 64'h2A);
        chk("t1_fill",  64'(fill_count), 64'd1);
        pop1();
        chk("t1_fill_pop",  64'(fill_count), 64'd0);
        chk("t1_valid_pop", 64'(trc_valid), 64'd0);

        // Dual event: REG first, STORE second, same stamp.
        reg_write_sig = 1'b1; reg_num = 5'd3; reg_data = 32'h11;
        wr = 1'b1; addr = 9'h010; wr_data = 32'hDEAD_BEEF;
        cyc();
        idle();
        chk("t2_fill",   64'(fill_count), 64'd2);
        chk("t2_kind0",  64'(trc_kind), 64'd0);
        chk("t2_index0", 64'(trc_index), 64'd3);
        chk("t2_data0",  64'(trc_data), 64'h11);
        ts_a = trc_ts;
`ifndef TRACE_TIMESTAMP_EN
        chk("t2_ts_zero", 64'(trc_ts), 64'd0);
`endif
        pop1();
        chk("t2_kind1",  64'(trc_kind), 64'd1);
        chk("t2_index1", 64'(trc_index), 64'h010);
        chk("t2_data1",  64'(trc_data), 64'hDEAD_BEEF);
        chk("t2_ts_eq",  64'(trc_ts), 64'(ts_a));
        chk("t2_fill1",  64'(fill_count), 64'd1);
        pop1();
        chk("t2_empty",  64'(fill_count), 64'd0);

        // x0 write ignored, LOAD recorded.
        reg_write_sig = 1'b1; reg_num = 5'd0; reg_data = 32'h99;
        reade = 1'b1; addr = 9'h020; rd_data = 32'h7;
        cyc();
        idle();
        chk("t3_fill",  64'(fill_count), 64'd1);
        chk("t3_kind",  64'(trc_kind), 64'd2);
        chk("t3_index", 64'(trc_index), 64'h020);
        chk("t3_data",  64'(trc_data), 64'h7);
        pop1();

        // wr and reade together count as a STORE.
        wr = 1'b1; reade = 1'b1; addr = 9'h033; wr_data = 32'h1234; rd_data = 32'h5678;
        cyc();
        idle();
        chk("t4_kind", 64'(trc_kind), 64'd1);
        chk("t4_data", 64'(trc_data), 64'h1234);
        pop1();

        // trace_en=0 captures nothing and keeps existing entries.
        push_reg(5'd7, 32'd7);
        trace_en = 1'b0;
        push_reg(5'd8, 32'd8);
        chk("t5_fill",  64'(fill_count), 64'd1);
        chk("t5_index", 64'(trc_index), 64'd7);
        trace_en = 1'b1;
        pop1();
        chk("t5_empty", 64'(fill_count), 64'd0);

        // Fill 16, then one more REG and a dual event: three drops.
        for (int i = 1; i <= 16; i++) push_reg(5'(i), 32'(i));
        chk("t6_full", 64'(fill_count), 64'd16);
        chk("t6_ovf0", 64'(overflow), 64'd0);
        push_reg(5'd17, 32'd17);
        reg_write_sig = 1'b1; reg_num = 5'd18; reg_data = 32'd18;
        wr = 1'b1; addr = 9'h040; wr_data = 32'h40;
        cyc();
        idle();
        chk("t6_fill", 64'(fill_count), 64'd16);
        chk("t6_ovf",  64'(overflow), 64'd1);
        chk("t6_drop", 64'(drop_count), 64'd3);
        chk("t6_head", 64'(trc_index), 64'd1);
        clr_ovf = 1'b1;
        cyc();
        clr_ovf = 1'b0;
        chk("t6_clr_ovf",  64'(overflow), 64'd0);
        chk("t6_clr_drop", 64'(drop_count), 64'd0);
        trc_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk("t6_order", 64'(trc_data), 64'(i));
            cyc();
        end
        trc_ready = 1'b0;
        chk("t6_drained", 64'(fill_count), 64'd0);

        // Fill to 15, dual event: REG in, MEM dropped.
        for (int i = 1; i <= 15; i++) push_reg(5'(i), 32'h100 + 32'(i));
        reg_write_sig = 1'b1; reg_num = 5'd31; reg_data = 32'hAA;
        wr = 1'b1; addr = 9'h1FF; wr_data = 32'h55;
        cyc();
        idle();
        chk("t7_fill", 64'(fill_count), 64'd16);
        chk("t7_drop", 64'(drop_count), 64'd1);
        chk("t7_ovf",  64'(overflow), 64'd1);
        // Clear wins over a same-cycle drop.
        clr_ovf = 1'b1;
        push_reg(5'd9, 32'd9);
        clr_ovf = 1'b0;
        chk("t7_clr_ovf",  64'(overflow), 64'd0);
        chk("t7_clr_drop", 64'(drop_count), 64'd0);
        chk("t7_clr_fill", 64'(fill_count), 64'd16);
        // A pop does not make room for the same cycle's push.
        trc_ready = 1'b1;
        push_reg(5'd10, 32'd10);
        trc_ready = 1'b0;
        chk("t7_pp_fill", 64'(fill_count), 64'd15);
        chk("t7_pp_drop", 64'(drop_count), 64'd1);
        chk("t7_pp_head", 64'(trc_index), 64'd2);

        // Reset while loaded clears everything regardless of trc_ready.
        trc_ready = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("t8_valid", 64'(trc_valid), 64'd0);
        chk("t8_fill",  64'(fill_count), 64'd0);
        chk("t8_ovf",   64'(overflow), 64'd0);
        chk("t8_drop",  64'(drop_count), 64'd0);
        for (int i = 1; i <= 5; i++) push_reg(5'(i), 32'(i));
        chk("t8_fill5", 64'(fill_count), 64'd5);
        trc_ready = 1'b1;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        trc_ready = 1'b0;
        chk("t8_valid5", 64'(trc_valid), 64'd0);
        chk("t8_empty5", 64'(fill_count), 64'd0);
        chk("t8_data5",  64'(trc_data), 64'd0);

`ifdef TRACE_TIMESTAMP_EN
        // Two captures exactly 2^16 cycles apart carry equal stamps.
        push_reg(5'd9, 32'd1);
        repeat (65535) cyc();
        push_reg(5'd10, 32'd2);
        chk("t9_fill", 64'(fill_count), 64'd2);
        ts_a = trc_ts;
        pop1();
        chk("t9_index", 64'(trc_index), 64'd10);
        chk("t9_wrap",  64'(trc_ts), 64'(ts_a));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
